// File: rtl/rtp_rx_depack.sv
// RTP/L16 receive depacketizer: validates the 12-byte RTP header of each UDP
// packet and buffers big-endian 16-bit payload samples for the codec play path.
module rtp_rx_depack #(
  parameter logic [7:0]  RTP_BYTE0 = 8'h80,
  parameter logic [31:0] SSRC      = 32'h12345678,
  parameter int          FIFO_AW   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               udp_rec_data_valid,
  input  logic [7:0]         udp_rec_rdata,
  input  logic [15:0]        udp_rec_data_length,
  input  logic               wav_rden,
  output logic [15:0]        wav_out_data,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [15:0]        pkt_ok_cnt,
  output logic [15:0]        pkt_drop_cnt,
  output logic               seq_err,
  output logic               underrun
);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;
  state_t state, state_nx;

  logic              valid_q, first_pkt, ssrc_ok;
  logic [15:0]       len, idx, seq, last_seq, need;
  logic [7:0]        hi, ssrc_byte;
  logic [16:0]       free_sp;
  logic [15:0]       mem [DEPTH];
  logic [FIFO_AW:0]  wr_ptr, rd_ptr;
  logic              start, hdr_bad, ssrc_final, accept, drop_inc, wr_en, rd_en, empty;

  assign start      = udp_rec_data_valid && !valid_q;
  assign hdr_bad    = (udp_rec_data_length < 16'd12) || udp_rec_data_length[0] ||
                      (udp_rec_rdata != RTP_BYTE0);
  assign ssrc_final = ssrc_ok && (udp_rec_rdata == SSRC[7:0]);
  assign need       = (len - 16'd12) >> 1;
  assign free_sp    = 17'(DEPTH) - 17'(fifo_level);
  assign empty      = (wr_ptr == rd_ptr);
  assign rd_en      = wav_rden && !empty;

  always_comb begin
    case (idx[1:0])
      2'd0:    ssrc_byte = SSRC[31:24];
      2'd1:    ssrc_byte = SSRC[23:16];
      2'd2:    ssrc_byte = SSRC[15:8];
      default: ssrc_byte = SSRC[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    drop_inc = 1'b0;
    wr_en    = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (hdr_bad) begin state_nx = DROP; drop_inc = 1'b1; end
        else                state_nx = HDR;
      end
      HDR: begin
        if (!udp_rec_data_valid) begin
          state_nx = IDLE; drop_inc = 1'b1;
        end else if (idx == 16'd11) begin
          // Space check is for the whole packet so a packet is never split.
          if (!ssrc_final || free_sp < 17'(need)) begin
            state_nx = DROP; drop_inc = 1'b1;
          end else begin
            accept   = 1'b1;
            state_nx = (len == 16'd12) ? IDLE : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (!udp_rec_data_valid) begin
          state_nx = IDLE; drop_inc = 1'b1;
        end else begin
          wr_en = idx[0];
          if (idx == len - 16'd1) state_nx = IDLE;
        end
      end
      DROP: if (!udp_rec_data_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= {hi, udp_rec_rdata};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // valid_q starts high so a packet already in flight is never picked up mid-stream
      valid_q      <= 1'b1;
      first_pkt    <= 1'b1;
      ssrc_ok      <= 1'b0;
      len          <= '0;
      idx          <= '0;
      seq          <= '0;
      last_seq     <= '0;
      hi           <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      wav_out_data <= '0;
      pkt_ok_cnt   <= '0;
      pkt_drop_cnt <= '0;
      seq_err      <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      valid_q <= udp_rec_data_valid;

      if (state == IDLE && start) begin
        len <= udp_rec_data_length;
        idx <= 16'd1;
      end else if (udp_rec_data_valid && (state == HDR || state == PAYLOAD)) begin
        idx <= idx + 16'd1;
      end

      if (state == HDR && udp_rec_data_valid) begin
        case (idx)
          16'd2:  seq[15:8] <= udp_rec_rdata;
          16'd3:  seq[7:0]  <= udp_rec_rdata;
          16'd8:  ssrc_ok   <= (udp_rec_rdata == ssrc_byte);
          16'd9, 16'd10: ssrc_ok <= ssrc_ok && (udp_rec_rdata == ssrc_byte);
          default: ;
        endcase
      end

      if (state == PAYLOAD && udp_rec_data_valid && !idx[0]) hi <= udp_rec_rdata;

      seq_err <= accept && !first_pkt && (seq != last_seq + 16'd1);
      if (accept) begin
        last_seq  <= seq;
        first_pkt <= 1'b0;
        if (pkt_ok_cnt != 16'hFFFF) pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
      end
      if (drop_inc && pkt_drop_cnt != 16'hFFFF) pkt_drop_cnt <= pkt_drop_cnt + 16'd1;

      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        wav_out_data <= mem[rd_ptr[FIFO_AW-1:0]];
        rd_ptr       <= rd_ptr + 1'b1;
      end else if (wav_rden) begin
        wav_out_data <= '0;
      end
      underrun   <= wav_rden && empty;
      fifo_level <= fifo_level + (FIFO_AW+1)'(wr_en) - (FIFO_AW+1)'(rd_en);
    end
  end
endmodule

// File: tb/tb_rtp_rx_depack.sv
// Directed bench for rtp_rx_depack; a scoreboard queue of expected samples is
// filled by the packet driver and drained by an independent read monitor.
module tb_rtp_rx_depack;
  typedef logic [7:0] bq_t[$];

  logic        clk = 0, rst_n = 0;
  logic        udp_rec_data_valid = 0;
  logic [7:0]  udp_rec_rdata = 0;
  logic [15:0] udp_rec_data_length = 0;
  logic        wav_rden = 0;
  logic [15:0] wav_out_data;
  logic [10:0] fifo_level;
  logic [15:0] pkt_ok_cnt, pkt_drop_cnt;
  logic        seq_err, underrun;

  rtp_rx_depack dut (
    .clk(clk), .rst_n(rst_n),
    .udp_rec_data_valid(udp_rec_data_valid), .udp_rec_rdata(udp_rec_rdata),
    .udp_rec_data_length(udp_rec_data_length), .wav_rden(wav_rden),
    .wav_out_data(wav_out_data), .fifo_level(fifo_level),
    .pkt_ok_cnt(pkt_ok_cnt), .pkt_drop_cnt(pkt_drop_cnt),
    .seq_err(seq_err), .underrun(underrun));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, seq_err_cnt = 0, rd_cnt = 0;
  bit rd_always = 0;

  logic        exp_wr = 0;
  logic [15:0] exp_wd = 0;
  logic [15:0] sb[$];
  logic        rd_pend = 0, rd_pend_und = 0;
  logic [15:0] rd_pend_val = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard model: a read in a cycle sees only writes from earlier cycles.
  always @(posedge clk) begin
    if (!rst_n) begin
      sb.delete();
      rd_pend = 0; rd_pend_und = 0; rd_pend_val = 0;
    end else begin
      rd_pend = wav_rden;
      rd_pend_und = 0;
      if (wav_rden) begin
        if (sb.size() > 0) rd_pend_val = sb.pop_front();
        else begin rd_pend_val = 0; rd_pend_und = 1; end
      end
      if (exp_wr) sb.push_back(exp_wd);
    end
  end

  always @(negedge clk) begin
    if (seq_err === 1'b1) seq_err_cnt++;
    chk("underrun", underrun, rd_pend_und);
    if (rd_pend) chk("wav_out_data", wav_out_data, rd_pend_val);
  end

  always @(negedge clk) begin
    wav_rden = rd_always || (rd_cnt > 0);
    if (rd_cnt > 0) rd_cnt--;
  end

  function automatic bq_t build(input logic [7:0] b0, input logic [15:0] seq,
                                input logic [31:0] ssrc, input bq_t pl);
    bq_t q;
    q = {b0, 8'h00, seq[15:8], seq[7:0], 8'hA0, 8'hA1, 8'hA2, 8'hA3,
         ssrc[31:24], ssrc[23:16], ssrc[15:8], ssrc[7:0]};
    foreach (pl[k]) q.push_back(pl[k]);
    return q;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic [15:0] l,
                       input logic w, input logic [15:0] wd);
    @(negedge clk);
    udp_rec_data_valid = v; udp_rec_rdata = d; udp_rec_data_length = l;
    exp_wr = w; exp_wd = wd;
  endtask

  // Sends bytes [from,to) of pkt; 'acc' marks the packet as expected to be stored.
  task automatic send_bytes(input bq_t b, input logic [15:0] len, input int from,
                            input int to, input bit acc, input bit tail);
    for (int i = from; i < to; i++) begin
      logic w;
      logic [15:0] wd;
      w = acc && i >= 13 && (i % 2 == 1) && i < len;
      wd = w ? {b[i-1], b[i]} : 16'h0;
      drive(1'b1, b[i], len, w, wd);
    end
    if (tail) begin
      drive(1'b0, 8'h00, 16'h0, 1'b0, 16'h0);
      drive(1'b0, 8'h00, 16'h0, 1'b0, 16'h0);
    end
  endtask

  task automatic send_pkt(input logic [15:0] len, input logic [15:0] seq,
                          input logic [31:0] ssrc, input logic [7:0] b0,
                          input bq_t pl, input int nsend, input bit acc);
    bq_t b;
    b = build(b0, seq, ssrc, pl);
    send_bytes(b, len, 0, nsend, acc, 1'b1);
  endtask

  task automatic do_reads(input int n);
    int t;
    @(posedge clk);
    rd_cnt = n;
    t = 0;
    @(posedge clk);
    while ((rd_cnt > 0 || wav_rden) && t < 5000) begin @(posedge clk); t++; end
    chk("read_timeout", t < 5000, 1);
    @(negedge clk);
  endtask

  task automatic status(input string nm, input int ok, input int dr, input int lvl);
    chk({nm, "_ok"}, pkt_ok_cnt, ok);
    chk({nm, "_drop"}, pkt_drop_cnt, dr);
    chk({nm, "_level"}, fifo_level, lvl);
  endtask

  initial begin
    bq_t pl, b;
    int se0;
    repeat (2) @(negedge clk);
    status("reset", 0, 0, 0);
    chk("reset_wav", wav_out_data, 0);
    chk("reset_seq_err", seq_err, 0);
    rst_n = 1;
    @(negedge clk);

    // Basic packet, then drain past empty
    send_pkt(16, 16'h0005, 32'h12345678, 8'h80, '{8'h12, 8'h34, 8'hAB, 8'hCD}, 16, 1);
    status("pktA", 1, 0, 2);
    do_reads(3);
    chk("pktA_drained", fifo_level, 0);

    // Sequence discontinuity and wrap
    se0 = seq_err_cnt;
    send_pkt(12, 16'h0007, 32'h12345678, 8'h80, '{}, 12, 1);
    chk("seq_5_7", seq_err_cnt - se0, 1);
    send_pkt(12, 16'hFFFF, 32'h12345678, 8'h80, '{}, 12, 1);
    chk("seq_7_ffff", seq_err_cnt - se0, 2);
    send_pkt(12, 16'h0000, 32'h12345678, 8'h80, '{}, 12, 1);
    chk("seq_wrap", seq_err_cnt - se0, 2);
    status("seq", 4, 0, 0);

    // Header rejects
    send_pkt(16, 16'h0001, 32'h12345679, 8'h80, '{8'h11, 8'h22, 8'h33, 8'h44}, 16, 0);
    status("bad_ssrc", 4, 1, 0);
    send_pkt(16, 16'h0001, 32'h12345678, 8'h90, '{8'h11, 8'h22, 8'h33, 8'h44}, 16, 0);
    status("bad_b0", 4, 2, 0);
    send_pkt(15, 16'h0001, 32'h12345678, 8'h80, '{8'h11, 8'h22, 8'h33}, 15, 0);
    status("odd_len", 4, 3, 0);

    // Prefill to 1020 samples in four 255-sample packets (seq 1..4)
    for (int p = 1; p <= 4; p++) begin
      pl.delete();
      for (int k = 0; k < 255; k++) begin
        pl.push_back(8'(p));
        pl.push_back(8'(k));
      end
      send_pkt(16'd522, 16'(p), 32'h12345678, 8'h80, pl, 522, 1);
    end
    status("prefill", 8, 3, 1020);
    pl.delete();
    for (int k = 0; k < 10; k++) pl.push_back(8'(8'hE0 + k));
    send_pkt(22, 16'h0005, 32'h12345678, 8'h80, pl, 22, 0);
    status("no_space", 8, 4, 1020);
    pl.delete();
    for (int k = 0; k < 8; k++) pl.push_back(8'(8'hF0 + k));
    send_pkt(20, 16'h0005, 32'h12345678, 8'h80, pl, 20, 1);
    status("fill_full", 9, 4, 1024);
    chk("fill_seq", seq_err_cnt - se0, 2);
    do_reads(1024);
    chk("full_drained", fifo_level, 0);

    // Truncation after 3 payload bytes keeps one sample
    send_pkt(20, 16'h0006, 32'h12345678, 8'h80,
             '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC}, 15, 1);
    status("trunc", 10, 5, 1);
    send_pkt(16, 16'h0007, 32'h12345678, 8'h80, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 16, 1);
    status("after_trunc", 11, 5, 3);
    chk("trunc_seq", seq_err_cnt - se0, 2);
    do_reads(3);

    // Continuous reads overlapping payload writes
    @(posedge clk);
    rd_always = 1;
    send_pkt(20, 16'h0008, 32'h12345678, 8'h80,
             '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 20, 1);
    @(posedge clk);
    rd_always = 0;
    repeat (3) @(negedge clk);
    status("cont_rd", 12, 5, 0);
    chk("cont_sb_empty", sb.size(), 0);

    // Reset in the middle of a packet; the rest of it must be ignored
    b = build(8'h80, 16'h0009, 32'h12345678,
              '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80});
    send_bytes(b, 20, 0, 14, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 0; udp_rec_rdata = b[14]; exp_wr = 0;
    @(negedge clk);
    status("mid_rst", 0, 0, 0);
    chk("mid_rst_wav", wav_out_data, 0);
    chk("mid_rst_seq_err", seq_err, 0);
    rst_n = 1;
    send_bytes(b, 20, 15, 20, 1'b0, 1'b1);
    status("post_rst_tail", 0, 0, 0);
    se0 = seq_err_cnt;
    send_pkt(16, 16'h0020, 32'h12345678, 8'h80, '{8'hC0, 8'hDE, 8'hF0, 8'h0D}, 16, 1);
    status("post_rst_pkt", 1, 0, 2);
    chk("post_rst_first_seq", seq_err_cnt - se0, 0);
    do_reads(2);
    chk("final_sb_empty", sb.size(), 0);
    chk("final_level", fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
